serial_sub: RTL and testbench



---
 rtl/serial_sub_if.sv | 26 ++
 rtl/serial_sub.sv | 110 +++++++++++
 tb/tb_serial_sub.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/serial_sub_if.sv
// Start/done bus for the bit-serial subtractor.
// The master presents operands and a request; the slave returns status and the registered result.
interface serial_sub_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  start;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic                  bin;
  logic                  ready;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] diff;
  logic                  bout;
  logic                  ovf;

  modport master (
    output start, a, b, bin,
    input  ready, busy, done, diff, bout, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output ready, busy, done, diff, bout, ovf
  );
endinterface

// File: rtl/serial_sub.sv
// Bit-serial ripple-borrow subtractor: DIFF = A - B - BIN, one full-subtractor step per clock, LSB first.
// Operands are captured on an accepted start; results are registered and held until the next completion.
module serial_sub #(
  parameter int DATA_WIDTH = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  serial_sub_if.slave  bus
);
  localparam int CW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] aReg_q;
  logic [DATA_WIDTH-1:0] bReg_q;
  logic [DATA_WIDTH-1:0] res_q;
  logic                  brw_q;
  logic [CW-1:0]         cnt_q;
  logic                  aMsb_q;
  logic                  bMsb_q;
  logic                  ready_q;
  logic                  busy_q;
  logic                  done_q;
  logic [DATA_WIDTH-1:0] diff_q;
  logic                  bout_q;
  logic                  ovf_q;

  logic                  aBit;
  logic                  bBit;
  logic                  diffBit_d;
  logic                  brw_d;

  // The single full-subtractor cell shared by every bit position.
  always_comb begin
    aBit      = aReg_q[0];
    bBit      = bReg_q[0];
    diffBit_d = aBit ^ bBit ^ brw_q;
    brw_d     = (~aBit & bBit) | (~(aBit ^ bBit) & brw_q);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      aReg_q  <= '0;
      bReg_q  <= '0;
      res_q   <= '0;
      brw_q   <= 1'b0;
      cnt_q   <= '0;
      aMsb_q  <= 1'b0;
      bMsb_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            aReg_q  <= bus.a;
            bReg_q  <= bus.b;
            brw_q   <= bus.bin;
            aMsb_q  <= bus.a[DATA_WIDTH-1];
            bMsb_q  <= bus.b[DATA_WIDTH-1];
            res_q   <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          res_q  <= {diffBit_d, res_q[DATA_WIDTH-1:1]};
          aReg_q <= aReg_q >> 1;
          bReg_q <= bReg_q >> 1;
          brw_q  <= brw_d;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == CW'(DATA_WIDTH - 1)) begin
            busy_q  <= 1'b0;
            state_q <= FIN;
          end
        end
        FIN: begin
          // Signed overflow only possible when operand signs differ and the result sign departs from A.
          diff_q  <= res_q;
          bout_q  <= brw_q;
          ovf_q   <= (aMsb_q != bMsb_q) & (res_q[DATA_WIDTH-1] != aMsb_q);
          done_q  <= 1'b1;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.diff  = diff_q;
  assign bus.bout  = bout_q;
  assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: a table of hand-computed vectors plus
// directed sequences for busy-ignore, mid-operation reset and back-to-back starts.
module tb_serial_sub;
  localparam int W = 8;

  logic clk;
  logic rstN;
  int   checks;
  int   passed;

  serial_sub_if #(.DATA_WIDTH(W)) bus ();

  serial_sub #(.DATA_WIDTH(W)) dut (
    .clk_i  (clk),
    .rst_ni (rstN),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] expDiff;
    logic         expBout;
    logic         expOvf;
  } vec_t;

  vec_t vecs [10];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Waits for DONE, counting cycles and busy cycles; n = -1 on timeout.
  task automatic waitDone(output int n, output int busyCnt);
    n = -1;
    busyCnt = 0;
    for (int i = 1; i <= 25; i++) begin
      @(posedge clk); #1;
      if (bus.busy) busyCnt++;
      if (bus.done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                               input logic [W-1:0] expDiff, input logic expBout, input logic expOvf);
    int n;
    int busyCnt;
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.bin   = bin;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
    bus.bin   = 1'($urandom);
    checkOutput("busy_after_accept", 32'(bus.busy), 32'(1));
    checkOutput("ready_after_accept", 32'(bus.ready), 32'(0));
    waitDone(n, busyCnt);
    checkOutput("latency", 32'(n), 32'(W + 1));
    checkOutput("busy_cycles", 32'(busyCnt + 1), 32'(W));
    checkOutput("diff", 32'(bus.diff), 32'(expDiff));
    checkOutput("bout", 32'(bus.bout), 32'(expBout));
    checkOutput("ovf", 32'(bus.ovf), 32'(expOvf));
    checkOutput("ready_at_done", 32'(bus.ready), 32'(1));
    @(posedge clk); #1;
    checkOutput("done_one_cycle", 32'(bus.done), 32'(0));
  endtask

  initial begin
    int n;
    int busyCnt;
    int doneCnt;
    checks = 0;
    passed = 0;

    vecs[0] = '{8'h50, 8'h30, 1'b0, 8'h20, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[3] = '{8'h05, 8'h05, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[5] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[6] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, 1'b1};
    vecs[7] = '{8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0, 1'b1};
    vecs[8] = '{8'h3C, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[9] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};

    rstN      = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.bin   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_ready", 32'(bus.ready), 32'(1));
    checkOutput("rst_busy", 32'(bus.busy), 32'(0));
    checkOutput("rst_done", 32'(bus.done), 32'(0));
    checkOutput("rst_diff", 32'(bus.diff), 32'(0));
    checkOutput("rst_bout", 32'(bus.bout), 32'(0));
    checkOutput("rst_ovf", 32'(bus.ovf), 32'(0));
    rstN = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++)
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].expDiff, vecs[i].expBout, vecs[i].expOvf);

    // Reset mid-operation: outputs currently hold 0x80/1/1 from the last vector.
    bus.start = 1'b1;
    bus.a     = 8'hF0;
    bus.b     = 8'h0F;
    bus.bin   = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rstN = 1'b0;
    @(posedge clk); #1;
    rstN = 1'b1;
    checkOutput("midrst_ready", 32'(bus.ready), 32'(1));
    checkOutput("midrst_busy", 32'(bus.busy), 32'(0));
    checkOutput("midrst_diff", 32'(bus.diff), 32'(0));
    checkOutput("midrst_bout", 32'(bus.bout), 32'(0));
    checkOutput("midrst_ovf", 32'(bus.ovf), 32'(0));
    doneCnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (bus.done) doneCnt++;
    end
    checkOutput("midrst_no_done", 32'(doneCnt), 32'(0));

    // Busy ignore: a second request during RUN must not be taken.
    bus.start = 1'b1;
    bus.a     = 8'h10;
    bus.b     = 8'h01;
    bus.bin   = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.a     = 8'hAA;
    bus.b     = 8'h55;
    repeat (4) @(posedge clk);
    #1;
    bus.start = 1'b0;
    doneCnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        doneCnt++;
        checkOutput("ignore_diff", 32'(bus.diff), 32'(8'h0F));
        checkOutput("ignore_bout", 32'(bus.bout), 32'(0));
      end
    end
    checkOutput("ignore_single_done", 32'(doneCnt), 32'(1));
    checkOutput("ignore_idle_after", 32'(bus.busy), 32'(0));

    // Back-to-back with START held high.
    bus.start = 1'b1;
    bus.a     = 8'h03;
    bus.b     = 8'h01;
    bus.bin   = 1'b0;
    @(posedge clk); #1;
    waitDone(n, busyCnt);
    checkOutput("b2b_first_latency", 32'(n), 32'(W + 1));
    checkOutput("b2b_first_diff", 32'(bus.diff), 32'(8'h02));
    checkOutput("b2b_first_bout", 32'(bus.bout), 32'(0));
    bus.a = 8'h01;
    bus.b = 8'h03;
    waitDone(n, busyCnt);
    checkOutput("b2b_spacing", 32'(n), 32'(W + 2));
    checkOutput("b2b_second_diff", 32'(bus.diff), 32'(8'hFE));
    checkOutput("b2b_second_bout", 32'(bus.bout), 32'(1));
    checkOutput("b2b_second_ovf", 32'(bus.ovf), 32'(0));
    bus.start = 1'b0;
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
